// File: rtl/lab4_net_param_bus_net.sv
// lab4_net_param_bus_net
//
// N-port shared-bus message network. Every cycle a round-robin arbiter picks
// at most one input whose destination queue has room. That message moves over
// the single bus into the tail of the per-output FIFO named by its header
// dest field. Each output FIFO drains independently through its own
// val/rdy handshake.
//
// Header layout is {opaque, src, dest}, with dest in the LSBs. The network
// never modifies the header.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset (0 = in reset)
//   in_val          per-input valid
//   in_rdy          per-input ready; one-hot (the granted port) or zero
//   in_msg_hdr      packed input headers, port i in slice i
//   in_msg_payload  packed input payloads, port i in slice i
//   out_val         per-output valid (queue not empty)
//   out_rdy         per-output ready
//   out_msg_hdr     packed head-of-queue headers
//   out_msg_payload packed head-of-queue payloads
module lab4_net_param_bus_net #(
  parameter int p_num_ports     = 4,
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 8,
  parameter int p_queue_depth   = 2,
  localparam int c_id_nbits     = $clog2(p_num_ports),
  localparam int c_hdr_nbits    = p_opaque_nbits + 2*c_id_nbits
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_ports-1:0]               in_val,
  output logic [p_num_ports-1:0]               in_rdy,
  input  logic [p_num_ports*c_hdr_nbits-1:0]   in_msg_hdr,
  input  logic [p_num_ports*p_payload_nbits-1:0] in_msg_payload,
  output logic [p_num_ports-1:0]               out_val,
  input  logic [p_num_ports-1:0]               out_rdy,
  output logic [p_num_ports*c_hdr_nbits-1:0]   out_msg_hdr,
  output logic [p_num_ports*p_payload_nbits-1:0] out_msg_payload
);

  localparam int c_cnt_nbits = $clog2(p_queue_depth + 1);
  localparam int c_idx_nbits = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
  // Storage is rounded up to a power of two so head/tail index it exactly;
  // slots at or beyond p_queue_depth are never written.
  localparam int c_slots     = 1 << c_idx_nbits;
  localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_queue_depth);
  localparam logic [c_idx_nbits-1:0] c_last  = c_idx_nbits'(p_queue_depth - 1);

  logic [c_id_nbits-1:0]      ptr;
  logic [c_cnt_nbits-1:0]     count [p_num_ports];
  logic [c_idx_nbits-1:0]     head  [p_num_ports];
  logic [c_idx_nbits-1:0]     tail  [p_num_ports];
  logic [c_hdr_nbits-1:0]     hdr_mem [p_num_ports][c_slots];
  logic [p_payload_nbits-1:0] pay_mem [p_num_ports][c_slots];

  logic [c_id_nbits-1:0]      dest [p_num_ports];
  logic [p_num_ports-1:0]     cand;
  logic [c_id_nbits-1:0]      rr_idx;
  logic                       grant_vld;
  logic [c_id_nbits-1:0]      grant_id;
  logic [c_id_nbits-1:0]      grant_dest;
  logic [c_hdr_nbits-1:0]     grant_hdr;
  logic [p_payload_nbits-1:0] grant_pay;
  logic [p_num_ports-1:0]     enq;
  logic [p_num_ports-1:0]     deq;

  // Candidate check uses the registered count only, so a same-cycle dequeue
  // never frees a slot and out_rdy stays out of the in_rdy path.
  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      dest[i] = in_msg_hdr[i*c_hdr_nbits +: c_id_nbits];
      cand[i] = in_val[i] && (count[dest[i]] < c_depth);
    end
  end

  // Round-robin search starting at ptr; the index wraps naturally because
  // p_num_ports is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = ptr;
    for (int k = 0; k < p_num_ports; k++) begin
      rr_idx = ptr + c_id_nbits'(k);
      if (!grant_vld && cand[rr_idx]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  assign grant_dest = dest[grant_id];
  assign grant_hdr  = in_msg_hdr[grant_id*c_hdr_nbits +: c_hdr_nbits];
  assign grant_pay  = in_msg_payload[grant_id*p_payload_nbits +: p_payload_nbits];

  // Ready is forced low while reset is asserted so no handshake is seen
  // during reset even though the arbiter inputs may look valid.
  assign in_rdy = (reset && grant_vld) ? (p_num_ports'(1) << grant_id) : '0;

  always_comb begin
    for (int j = 0; j < p_num_ports; j++) begin
      enq[j] = grant_vld && (grant_dest == c_id_nbits'(j));
      deq[j] = out_val[j] && out_rdy[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int j = 0; j < p_num_ports; j++) begin
        count[j] <= '0;
        head[j]  <= '0;
        tail[j]  <= '0;
        for (int s = 0; s < c_slots; s++) begin
          hdr_mem[j][s] <= '0;
          pay_mem[j][s] <= '0;
        end
      end
    end else begin
      if (grant_vld) begin
        ptr <= grant_id + 1'b1;
      end
      for (int j = 0; j < p_num_ports; j++) begin
        if (enq[j]) begin
          hdr_mem[j][tail[j]] <= grant_hdr;
          pay_mem[j][tail[j]] <= grant_pay;
          tail[j] <= (tail[j] == c_last) ? '0 : tail[j] + 1'b1;
        end
        if (deq[j]) begin
          head[j] <= (head[j] == c_last) ? '0 : head[j] + 1'b1;
        end
        count[j] <= count[j] + c_cnt_nbits'(enq[j]) - c_cnt_nbits'(deq[j]);
      end
    end
  end

  // Outputs come straight from registers.
  for (genvar j = 0; j < p_num_ports; j++) begin : g_out
    assign out_val[j] = (count[j] != '0);
    assign out_msg_hdr[j*c_hdr_nbits +: c_hdr_nbits]             = hdr_mem[j][head[j]];
    assign out_msg_payload[j*p_payload_nbits +: p_payload_nbits] = pay_mem[j][head[j]];
  end

endmodule

// File: doc/lab4_net_param_bus_net.md
# lab4_net_param_bus_net

Parametrised successor to the fixed 4-port bus network: an N-port, single-shared-bus message network with a round-robin arbiter and a per-output FIFO queue. It carries one message per cycle from any input to the output named in its header. It sits between processor-side and cache-side message adapters in the multicore memory system. Both the request network and the response network instantiate it with different payload widths.

## Interface
- p_num_ports, 4: number of input and output ports; must be a power of two, at least 2.
- p_payload_nbits, 32: payload width per message.
- p_opaque_nbits, 8: opaque header field width.
- p_queue_depth, 2: entries per output queue; at least 1.
- Derived constants:
  - c_id_nbits = clog2(p_num_ports).
  - c_hdr_nbits = p_opaque_nbits + 2*c_id_nbits.
  - Header layout is {opaque, src, dest}, with dest in the LSBs.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- in_val  in  p_num_ports  per-port input valid.
- in_rdy  out  p_num_ports  per-port input ready; one-hot or zero.
- in_msg_hdr  in  p_num_ports*c_hdr_nbits  packed headers; port i occupies slice i.
- in_msg_payload  in  p_num_ports*p_payload_nbits  packed payloads.
- out_val  out  p_num_ports  per-port output valid.
- out_rdy  in  p_num_ports  per-port output ready.
- out_msg_hdr  out  p_num_ports*c_hdr_nbits  head-of-queue header, unmodified from the input.
- out_msg_payload  out  p_num_ports*p_payload_nbits  head-of-queue payload.

## Operation
- Input port i is a candidate when in_val[i]=1 and the queue selected by its dest field has count < p_queue_depth.
  - Count is the registered value; a dequeue in the same cycle does not free the slot.
  - This keeps out_rdy out of any in_rdy path.
- Arbiter: round-robin over candidates.
  - Search starts at priority pointer ptr and proceeds ptr, ptr+1, … modulo p_num_ports.
  - The first candidate found is granted.
- in_rdy[g]=1 for the granted port g only; all other bits are 0. No candidates means in_rdy=0.
- On a transfer (in_val[g] & in_rdy[g]):
  - The header and payload are written unmodified into queue[dest_g] at its tail.
  - ptr <= (g+1) mod p_num_ports.
- No grant: ptr holds.
- A port whose destination is full is skipped. It does not block other ports.
- Per output queue: circular buffer with head, tail and count registers.
  - out_val[j] = (count_j != 0). out_msg_* = storage[head_j].
  - Dequeue on out_val[j] & out_rdy[j]: head advances, wrapping at p_queue_depth.
  - Enqueue and dequeue in the same cycle on a non-full queue: count unchanged, head and tail both advance.
  - Enqueue to a full queue cannot occur by construction.
- Messages from a single input to a single output are delivered in order.
- Messages arriving at an output from different inputs are ordered by grant cycle.

## Timing
- Latency: a message accepted in cycle t is presented with out_val=1 in cycle t+1 at the earliest.
- Throughput: at most one transfer per cycle across the whole network (shared bus).
- Each output drains at up to one message per cycle, independently of the others.
- in_rdy depends combinationally on in_val, the header dest fields, counts and ptr.
- out_val and out_msg_* depend only on registers.
- Reset (reset=0, asynchronous):
  - ptr, and all head, tail and count registers, go to 0; queue storage clears to 0.
  - Outputs during reset: out_val=0, out_msg_hdr=0, out_msg_payload=0, in_rdy=0 (forced while reset=0).
- Reset asserted mid-operation: all queued messages are discarded immediately. No transfer completes in a cycle where reset=0 at the edge.
- First grant is possible in the first cycle with reset=1.
- Invalid input headers (in_val=0) are ignored entirely.

## Test plan
- Single message: port 1 sends dest=2, payload 0xDEADBEEF → in_rdy=0b0010 that cycle; next cycle out_val=0b0100, out_msg carries 0xDEADBEEF and src=1.
- Fairness: all 4 inputs stay valid with dest=0 and out_rdy[0]=1 constantly → grants go 0,1,2,3,0,… one per cycle; output 0 receives them in that order.
- Full queue skip: depth=2, out_rdy[3]=0, ports 0 and 1 target dest=3 and port 2 targets dest=1 → port 2 is granted once queue 3 holds 2 entries; in_rdy[0] and in_rdy[1] stay 0 until out_rdy[3]=1.
- Wrap-around: depth=2, 6 messages to dest=0 with out_rdy toggling 1/0 → payloads emerge in send order; count never exceeds 2.
- Async reset: reset=0 between clock edges while queue 2 holds 1 entry → out_val=0 and in_rdy=0 immediately; after release, ptr=0 and port 0 wins a 4-way tie.
- Parameter sweep: p_num_ports=8, p_queue_depth=1, 64-bit payload, random traffic against a scoreboard → no loss, no duplication, per-pair ordering preserved.
